// File: rtl/fv_cmt_pkg.sv
// -----------------------------------------------------------------------------
// fv_cmt_pkg
// Shared definitions for the commit-throughput monitor: default parameter
// values, the monitor FSM state encoding and the sticky error-flag bundle.
// No ports (package).
// -----------------------------------------------------------------------------
package fv_cmt_pkg;

  localparam int FV_CMT_NUM_LANES   = 2;
  localparam int FV_CMT_CNT_W       = 32;
  localparam int FV_CMT_MAX_LATENCY = 16;
  localparam int FV_CMT_WARMUP      = 64;
  localparam int FV_CMT_STALL_LIMIT = 256;
  localparam int FV_CMT_MODE        = 0;
  localparam int FV_CMT_STALL_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAIL   = 2'd3
  } fv_cmt_state_t;

  typedef struct packed {
    logic latency;
    logic stall;
    logic overflow;
  } fv_cmt_err_t;

endpackage

// File: rtl/fv_cmt_monitor_if.sv
// -----------------------------------------------------------------------------
// fv_cmt_monitor_if
// Bundles the monitor's control inputs, commit strobes and status outputs.
//   master : the pipeline/environment side (drives enable, clear, commit,
//            EX_kill; observes counters, state and error flags)
//   slave  : the monitor side (fv_cmt_monitor)
// Parameters NUM_LANES and CNT_W must match the monitor instance.
// -----------------------------------------------------------------------------
interface fv_cmt_monitor_if
  import fv_cmt_pkg::*;
#(
  parameter int NUM_LANES = FV_CMT_NUM_LANES,
  parameter int CNT_W     = FV_CMT_CNT_W
);

  logic                      enable;
  logic                      clear;
  logic [NUM_LANES:1]        commit;
  logic                      EX_kill;
  logic [CNT_W-1:0]          clock_counter;
  logic [CNT_W-1:0]          num_committed;
  logic [FV_CMT_STALL_W-1:0] stall_count;
  fv_cmt_state_t             state;
  logic                      err_latency;
  logic                      err_stall;
  logic                      err_overflow;
  logic                      fail;

  modport master (
    output enable, clear, commit, EX_kill,
    input  clock_counter, num_committed, stall_count, state,
           err_latency, err_stall, err_overflow, fail
  );

  modport slave (
    input  enable, clear, commit, EX_kill,
    output clock_counter, num_committed, stall_count, state,
           err_latency, err_stall, err_overflow, fail
  );

endinterface

// File: rtl/fv_popcount.sv
// -----------------------------------------------------------------------------
// fv_popcount
// Counts the set bits of the per-lane commit strobe vector.
//   i_vec   [NUM_LANES:1]           commit strobes
//   o_count [$clog2(NUM_LANES+1)]   number of strobes set
// -----------------------------------------------------------------------------
module fv_popcount #(
  parameter  int NUM_LANES = 2,
  localparam int OUT_W     = $clog2(NUM_LANES + 1)
) (
  input  logic [NUM_LANES:1] i_vec,
  output logic [OUT_W-1:0]   o_count
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    o_count = '0;
    for (int i = 1; i <= NUM_LANES; i++) begin
      o_count = o_count + OUT_W'(i_vec[i]);
    end
  end

endmodule

// File: rtl/fv_cmt_monitor.sv
// -----------------------------------------------------------------------------
// fv_cmt_monitor
// Commit-throughput monitor. After enable it counts active cycles and
// committed instructions, flags a latency failure when the cycle count exceeds
// num_committed*MAX_LATENCY + WARMUP, optionally (MODE=1) flags runs of
// STALL_LIMIT non-committing cycles, and flags counter saturation.
//   clk    sole clock, rising edge
//   reset  synchronous active-high reset
//   bus    fv_cmt_monitor_if.slave: enable, clear, commit, EX_kill in;
//          clock_counter, num_committed, stall_count, state, err_* and fail out
// -----------------------------------------------------------------------------
module fv_cmt_monitor
  import fv_cmt_pkg::*;
#(
  parameter int NUM_LANES   = FV_CMT_NUM_LANES,
  parameter int CNT_W       = FV_CMT_CNT_W,
  parameter int MAX_LATENCY = FV_CMT_MAX_LATENCY,
  parameter int WARMUP      = FV_CMT_WARMUP,
  parameter int STALL_LIMIT = FV_CMT_STALL_LIMIT,
  parameter int MODE        = FV_CMT_MODE
) (
  input logic             clk,
  input logic             reset,
  fv_cmt_monitor_if.slave bus
);

  localparam int PC_W  = $clog2(NUM_LANES + 1);
  localparam int PRD_W = 2 * CNT_W;
  // One extra bit so product + WARMUP can never wrap.
  localparam int SUM_W = PRD_W + 1;
  localparam int SW    = FV_CMT_STALL_W;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [SW-1:0]    STALL_MAX = '1;
  localparam logic [PRD_W-1:0] LAT_EXT   = PRD_W'(MAX_LATENCY);
  localparam logic [SUM_W-1:0] WARM_EXT  = SUM_W'(WARMUP);
  localparam logic [31:0]      LIMIT_EXT = 32'(STALL_LIMIT);

  fv_cmt_state_t    r_state;
  fv_cmt_state_t    w_state_nxt;
  logic [CNT_W-1:0] r_clock_counter;
  logic [CNT_W-1:0] r_num_committed;
  logic [SW-1:0]    r_stall_count;
  logic [SW-1:0]    w_stall_nxt;
  fv_cmt_err_t      r_err;
  fv_cmt_err_t      w_err_nxt;

  logic [PC_W-1:0]  w_pop;
  logic [CNT_W:0]   w_cc_sum;
  logic [CNT_W:0]   w_nc_sum;
  logic [PRD_W-1:0] w_product;
  logic [SUM_W-1:0] w_budget;
  logic [SUM_W-1:0] w_cc_ext;
  logic             w_active;
  logic             w_in_run;
  logic             w_sat;
  logic             w_frozen;
  logic             w_any_commit;
  logic             w_warm_done;
  logic             w_latency_viol;

  fv_popcount #(.NUM_LANES(NUM_LANES)) u_popcount (
    .i_vec  (bus.commit),
    .o_count(w_pop)
  );

  assign w_active     = (r_state == ST_WARMUP) || (r_state == ST_RUN);
  assign w_in_run     = (r_state == ST_RUN);
  assign w_any_commit = |bus.commit;

  // Saturating adds: the carry-out bit selects all-ones.
  assign w_cc_sum = {1'b0, r_clock_counter} + (CNT_W + 1)'(1);
  assign w_nc_sum = {1'b0, r_num_committed} + (CNT_W + 1)'(w_pop);

  // Once either counter pins at all-ones its value is meaningless for the
  // ratio and stall checks, so both stop evaluating.
  assign w_sat    = (r_clock_counter == CNT_MAX) || (r_num_committed == CNT_MAX);
  assign w_frozen = w_sat || r_err.overflow;

  assign w_product      = {{CNT_W{1'b0}}, r_num_committed} * LAT_EXT;
  assign w_budget       = {1'b0, w_product} + WARM_EXT;
  assign w_cc_ext       = {{(SUM_W - CNT_W){1'b0}}, r_clock_counter};
  assign w_latency_viol = (w_cc_ext > w_budget);
  assign w_warm_done    = (r_num_committed != '0) || (w_cc_ext >= WARM_EXT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.enable) w_state_nxt = ST_WARMUP;
      ST_WARMUP: if (w_warm_done) w_state_nxt = ST_RUN;
      default:   w_state_nxt = r_state;
    endcase
    // Any registered error drives the FSM to FAIL from whatever state.
    if (r_err != '0) w_state_nxt = ST_FAIL;
  end

  always_comb begin
    w_stall_nxt = r_stall_count;
    if (MODE == 0) begin
      w_stall_nxt = '0;
    end else if (w_in_run && !w_frozen) begin
      // A commit alongside EX_kill still counts as a commit.
      if (w_any_commit) begin
        w_stall_nxt = '0;
      end else if (!bus.EX_kill && (r_stall_count != STALL_MAX)) begin
        w_stall_nxt = r_stall_count + SW'(1);
      end
    end
  end

  always_comb begin
    w_err_nxt = r_err;
    if (w_active && w_sat) w_err_nxt.overflow = 1'b1;
    if (w_in_run && !w_frozen) begin
      if (w_latency_viol) w_err_nxt.latency = 1'b1;
      if ((MODE == 1) && ({16'd0, r_stall_count} >= LIMIT_EXT)) w_err_nxt.stall = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      r_state         <= ST_IDLE;
      r_clock_counter <= '0;
      r_num_committed <= '0;
      r_stall_count   <= '0;
      r_err           <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Commits outside WARMUP/RUN are ignored; counters hold in IDLE/FAIL.
      if (w_active) begin
        r_clock_counter <= w_cc_sum[CNT_W] ? CNT_MAX : w_cc_sum[CNT_W-1:0];
        r_num_committed <= w_nc_sum[CNT_W] ? CNT_MAX : w_nc_sum[CNT_W-1:0];
      end
      r_stall_count <= w_stall_nxt;
      r_err         <= w_err_nxt;
    end
  end

  assign bus.state         = r_state;
  assign bus.clock_counter = r_clock_counter;
  assign bus.num_committed = r_num_committed;
  assign bus.stall_count   = r_stall_count;
  assign bus.err_latency   = r_err.latency;
  assign bus.err_stall     = r_err.stall;
  assign bus.err_overflow  = r_err.overflow;
  assign bus.fail          = |r_err;

endmodule

// File: tb/tb_fv_cmt_monitor.sv
// -----------------------------------------------------------------------------
// tb_fv_cmt_monitor
// Self-checking bench for fv_cmt_monitor. Three instances cover the default
// configuration, MODE=1 with STALL_LIMIT=8, and a 4-bit counter build with
// MAX_LATENCY=1. Expected per-cycle values are pushed to a scoreboard queue
// as stimulus is driven and popped once the DUT has registered them.
// -----------------------------------------------------------------------------
module tb_fv_cmt_monitor;
  import fv_cmt_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        flag;
  } exp_t;
  exp_t sb_q[$];

  fv_cmt_monitor_if #(.NUM_LANES(2), .CNT_W(32)) if_d ();
  fv_cmt_monitor_if #(.NUM_LANES(2), .CNT_W(32)) if_s ();
  fv_cmt_monitor_if #(.NUM_LANES(1), .CNT_W(4))  if_o ();

  fv_cmt_monitor #(.NUM_LANES(2), .CNT_W(32)) u_dflt (
    .clk(clk), .reset(reset), .bus(if_d)
  );
  fv_cmt_monitor #(.NUM_LANES(2), .CNT_W(32), .MODE(1), .STALL_LIMIT(8)) u_stall (
    .clk(clk), .reset(reset), .bus(if_s)
  );
  fv_cmt_monitor #(.NUM_LANES(1), .CNT_W(4), .MAX_LATENCY(1)) u_ovf (
    .clk(clk), .reset(reset), .bus(if_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse_d();
    if_d.clear = 1'b1; tick(); if_d.clear = 1'b0;
  endtask

  task automatic clear_pulse_s();
    if_s.clear = 1'b1; tick(); if_s.clear = 1'b0;
  endtask

  task automatic test_reset();
    // Reset must dominate enable and commits presented in the same cycles.
    reset = 1'b1;
    if_d.enable = 1'b1; if_d.clear = 1'b0; if_d.commit = 2'b11; if_d.EX_kill = 1'b0;
    if_s.enable = 1'b1; if_s.clear = 1'b0; if_s.commit = 2'b11; if_s.EX_kill = 1'b0;
    if_o.enable = 1'b1; if_o.clear = 1'b0; if_o.commit = 1'b1;  if_o.EX_kill = 1'b0;
    tick(); tick();
    reset = 1'b0;
    if_d.enable = 1'b0; if_d.commit = '0;
    if_s.enable = 1'b0; if_s.commit = '0;
    if_o.enable = 1'b0; if_o.commit = '0;
    checks++;
    if ({if_d.state, if_d.clock_counter, if_d.num_committed, if_d.stall_count,
         if_d.err_latency, if_d.err_stall, if_d.err_overflow, if_d.fail} !== '0) begin
      errors++;
      $display("FAIL reset_dflt: state=%0d cc=%0d nc=%0d sc=%0d fail=%b, required all 0",
               if_d.state, if_d.clock_counter, if_d.num_committed, if_d.stall_count, if_d.fail);
    end
    checks++;
    if ({if_s.state, if_s.clock_counter, if_s.num_committed, if_s.stall_count, if_s.fail} !== '0) begin
      errors++;
      $display("FAIL reset_stall: state=%0d cc=%0d nc=%0d sc=%0d fail=%b, required all 0",
               if_s.state, if_s.clock_counter, if_s.num_committed, if_s.stall_count, if_s.fail);
    end
    checks++;
    if ({if_o.state, if_o.clock_counter, if_o.num_committed, if_o.fail} !== '0) begin
      errors++;
      $display("FAIL reset_ovf: state=%0d cc=%0d nc=%0d fail=%b, required all 0",
               if_o.state, if_o.clock_counter, if_o.num_committed, if_o.fail);
    end
  endtask

  task automatic test_throughput();
    logic [31:0] m_cc = 0;
    logic [31:0] m_nc = 0;
    exp_t e;
    if_d.enable = 1'b1; tick(); if_d.enable = 1'b0;
    checks++;
    if (if_d.state !== ST_WARMUP) begin
      errors++;
      $display("FAIL tput_enter_warmup: state=%0d required %0d", if_d.state, ST_WARMUP);
    end
    for (int i = 0; i < 200; i++) begin
      if_d.commit = 2'b11;
      m_cc = m_cc + 1;
      m_nc = m_nc + 2;
      sb_q.push_back('{a: m_cc, b: m_nc, flag: 1'b0});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (if_d.clock_counter !== e.a || if_d.num_committed !== e.b || if_d.fail !== e.flag) begin
        errors++;
        $display("FAIL tput_cycle%0d: cc=%0d nc=%0d fail=%b required cc=%0d nc=%0d fail=0",
                 i, if_d.clock_counter, if_d.num_committed, if_d.fail, e.a, e.b);
      end
    end
    if_d.commit = '0;
    checks++;
    if (if_d.clock_counter !== 32'd200 || if_d.num_committed !== 32'd400 ||
        if_d.state !== ST_RUN || if_d.fail !== 1'b0) begin
      errors++;
      $display("FAIL tput_final: cc=%0d nc=%0d state=%0d fail=%b required 200/400/RUN/0",
               if_d.clock_counter, if_d.num_committed, if_d.state, if_d.fail);
    end
    clear_pulse_d();
  endtask

  task automatic test_latency();
    int n;
    bit early = 1'b0;
    logic [31:0] frozen_cc;
    if_d.enable = 1'b1; tick(); if_d.enable = 1'b0;
    for (n = 0; n < 150 && if_d.state !== ST_RUN; n++) begin
      if (if_d.err_latency !== 1'b0) early = 1'b1;
      tick();
    end
    checks++;
    if (if_d.state !== ST_RUN || early) begin
      errors++;
      $display("FAIL lat_reach_run: state=%0d early_err=%b required RUN with no error", if_d.state, early);
    end
    // RUN is entered on the edge after the registered count reaches WARMUP=64.
    checks++;
    if (if_d.clock_counter !== 32'd65 || if_d.err_latency !== 1'b0) begin
      errors++;
      $display("FAIL lat_run_entry: cc=%0d err=%b required cc=65 err=0",
               if_d.clock_counter, if_d.err_latency);
    end
    tick();
    checks++;
    if (if_d.err_latency !== 1'b1 || if_d.fail !== 1'b1 || if_d.state !== ST_RUN ||
        if_d.clock_counter !== 32'd66) begin
      errors++;
      $display("FAIL lat_flag: err=%b fail=%b state=%0d cc=%0d required 1/1/RUN/66",
               if_d.err_latency, if_d.fail, if_d.state, if_d.clock_counter);
    end
    tick();
    checks++;
    if (if_d.state !== ST_FAIL || if_d.stall_count !== 16'd0) begin
      errors++;
      $display("FAIL lat_to_fail: state=%0d sc=%0d required FAIL sc=0", if_d.state, if_d.stall_count);
    end
    frozen_cc = if_d.clock_counter;
    if_d.commit = 2'b11;
    tick(); tick();
    if_d.commit = '0;
    checks++;
    if (if_d.clock_counter !== frozen_cc || if_d.num_committed !== 32'd0 || if_d.state !== ST_FAIL) begin
      errors++;
      $display("FAIL lat_fail_frozen: cc=%0d nc=%0d state=%0d required cc=%0d nc=0 FAIL",
               if_d.clock_counter, if_d.num_committed, if_d.state, frozen_cc);
    end
  endtask

  task automatic test_clear_enable();
    // Starts in FAIL from test_latency.
    if_d.clear = 1'b1; if_d.enable = 1'b1;
    tick();
    if_d.clear = 1'b0;
    checks++;
    if (if_d.state !== ST_IDLE || if_d.clock_counter !== '0 || if_d.num_committed !== '0 ||
        if_d.fail !== 1'b0 || if_d.err_latency !== 1'b0) begin
      errors++;
      $display("FAIL clr_en_idle: state=%0d cc=%0d nc=%0d fail=%b required IDLE/0/0/0",
               if_d.state, if_d.clock_counter, if_d.num_committed, if_d.fail);
    end
    tick();
    if_d.enable = 1'b0;
    checks++;
    if (if_d.state !== ST_WARMUP || if_d.clock_counter !== '0) begin
      errors++;
      $display("FAIL clr_en_warmup: state=%0d cc=%0d required WARMUP cc=0",
               if_d.state, if_d.clock_counter);
    end
    clear_pulse_d();
  endtask

  task automatic test_reset_mid_run();
    if_d.enable = 1'b1; tick(); if_d.enable = 1'b0;
    if_d.commit = 2'b11; tick(); tick();
    checks++;
    if (if_d.state !== ST_RUN || if_d.num_committed !== 32'd4) begin
      errors++;
      $display("FAIL rst_run_setup: state=%0d nc=%0d required RUN nc=4", if_d.state, if_d.num_committed);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (if_d.state !== ST_IDLE || if_d.clock_counter !== '0 || if_d.num_committed !== '0 ||
        if_d.fail !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_run: state=%0d cc=%0d nc=%0d fail=%b required IDLE/0/0/0",
               if_d.state, if_d.clock_counter, if_d.num_committed, if_d.fail);
    end
    // commit is still 2'b11: IDLE must ignore it.
    tick();
    if_d.commit = '0;
    checks++;
    if (if_d.state !== ST_IDLE || if_d.num_committed !== '0) begin
      errors++;
      $display("FAIL idle_ignores_commit: state=%0d nc=%0d required IDLE nc=0",
               if_d.state, if_d.num_committed);
    end
  endtask

  task automatic stall_enter_run();
    if_s.enable = 1'b1; tick(); if_s.enable = 1'b0;
    if_s.commit = 2'b01; tick();
    if_s.commit = 2'b00; tick();
    // One commit in RUN, then the idle run starts.
    if_s.commit = 2'b10; tick();
    if_s.commit = 2'b00;
    checks++;
    if (if_s.state !== ST_RUN || if_s.stall_count !== 16'd0) begin
      errors++;
      $display("FAIL stall_setup: state=%0d sc=%0d required RUN sc=0", if_s.state, if_s.stall_count);
    end
  endtask

  task automatic run_stall(input logic [15:0] kill_mask, input int n_idle, input string tag);
    logic [31:0] m_sc = 0;
    logic        m_err = 1'b0;
    logic        k;
    exp_t        e;
    // One cycle beyond n_idle: the flag appears one edge after the limit count.
    for (int i = 0; i <= n_idle; i++) begin
      k = (i < n_idle) ? kill_mask[i] : 1'b0;
      if_s.EX_kill = k;
      m_err = m_err || (m_sc >= 32'd8);
      if (!k) m_sc = m_sc + 1;
      sb_q.push_back('{a: m_sc, b: 32'd0, flag: m_err});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (32'(if_s.stall_count) !== e.a || if_s.err_stall !== e.flag) begin
        errors++;
        $display("FAIL %s_cycle%0d: sc=%0d err_stall=%b required sc=%0d err_stall=%b",
                 tag, i, if_s.stall_count, if_s.err_stall, e.a, e.flag);
      end
    end
    if_s.EX_kill = 1'b0;
    tick();
    checks++;
    if (if_s.state !== ST_FAIL || if_s.err_stall !== 1'b1 || if_s.err_latency !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: state=%0d err_stall=%b err_lat=%b required FAIL/1/0",
               tag, if_s.state, if_s.err_stall, if_s.err_latency);
    end
  endtask

  task automatic test_stall();
    stall_enter_run();
    run_stall(16'h0000, 8, "stall_plain");
    clear_pulse_s();
    stall_enter_run();
    // EX_kill on idle cycles 2, 4 and 6.
    run_stall(16'h0054, 11, "stall_kill");
    clear_pulse_s();
    // Commit coinciding with EX_kill counts as a commit and zeroes the run.
    stall_enter_run();
    if_s.EX_kill = 1'b0; tick(); tick();
    if_s.commit = 2'b01; if_s.EX_kill = 1'b1; tick();
    if_s.commit = 2'b00; if_s.EX_kill = 1'b0;
    checks++;
    if (if_s.stall_count !== 16'd0 || if_s.num_committed !== 32'd3) begin
      errors++;
      $display("FAIL stall_commit_kill: sc=%0d nc=%0d required sc=0 nc=3",
               if_s.stall_count, if_s.num_committed);
    end
    clear_pulse_s();
  endtask

  task automatic test_overflow();
    logic [31:0] m_cc = 0;
    logic [31:0] m_nc = 0;
    logic        m_ovf = 1'b0;
    exp_t        e;
    if_o.enable = 1'b1; tick(); if_o.enable = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if_o.commit = 1'b1;
      m_ovf = m_ovf || (m_cc == 32'd15) || (m_nc == 32'd15);
      if (m_cc < 32'd15) m_cc = m_cc + 1;
      if (m_nc < 32'd15) m_nc = m_nc + 1;
      sb_q.push_back('{a: m_cc, b: m_nc, flag: m_ovf});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (32'(if_o.clock_counter) !== e.a || 32'(if_o.num_committed) !== e.b ||
          if_o.err_overflow !== e.flag || if_o.err_latency !== 1'b0) begin
        errors++;
        $display("FAIL ovf_cycle%0d: cc=%0d nc=%0d ovf=%b lat=%b required cc=%0d nc=%0d ovf=%b lat=0",
                 i, if_o.clock_counter, if_o.num_committed, if_o.err_overflow, if_o.err_latency,
                 e.a, e.b, e.flag);
      end
    end
    if_o.commit = '0;
    checks++;
    if (if_o.state !== ST_FAIL || if_o.fail !== 1'b1 || if_o.err_latency !== 1'b0) begin
      errors++;
      $display("FAIL ovf_final: state=%0d fail=%b err_lat=%b required FAIL/1/0",
               if_o.state, if_o.fail, if_o.err_latency);
    end
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_latency();
    test_clear_enable();
    test_reset_mid_run();
    test_stall();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
